alu_exec_stage: RTL
===================

// Module: alu_exec_stage
// PURPOSE
//   Registered execute-stage wrapper around the 64-bit signed ALU. Accepts
//   operations over a valid/ready handshake, computes OPCODE on in1/in2,
//   registers the result and overflow flag, and keeps the ZF/SF/OF condition
//   code register. Sits between decode and memory/writeback. It is the
//   responder for the decode-side operand stream.
// PARAMETERS
//   WIDTH     64   operand/result width; all arithmetic is two's complement
//   CC_RESET  3'b100  reset value of {ZF,SF,OF}
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      operation presented on OPCODE/in1/in2/set_cc
//   in_ready   out  1      stage can accept this cycle
//   OPCODE     in   2      00 add, 01 sub, 10 and, 11 xor
//   in1        in   WIDTH  signed operand A
//   in2        in   WIDTH  signed operand B
//   set_cc     in   1      update condition codes with this operation
//   out_valid  out  1      out/OF_FLAG hold a result
//   out_ready  in   1      downstream takes the result this cycle
//   out        out  WIDTH  registered result
//   OF_FLAG    out  1      registered signed-overflow flag for out
//   cc         out  3      {ZF,SF,OF} condition-code register
// BEHAVIOUR
//   Reset (async assert, sync-safe deassert): out_valid=0, out=0, OF_FLAG=0,
//     cc=CC_RESET. in_ready reads 1 once reset is released.
//   Arithmetic, wrap mod 2^WIDTH:
//     add: out=in1+in2; OF = sign(in1)==sign(in2) && sign(out)!=sign(in1).
//     sub: out=in1-in2; OF = sign(in1)!=sign(in2) && sign(out)!=sign(in1).
//     and/xor: bitwise; OF=0.
//   Handshake:
//     - Accept when in_valid && in_ready.
//     - Transfer when out_valid && out_ready.
//     - in_ready = !out_valid || out_ready (combinational from out_ready only).
//     - Latency: result visible on out/out_valid the cycle after accept.
//     - Throughput: 1 op/cycle while out_ready=1.
//   Output register:
//     - On accept, load out/OF_FLAG and set out_valid=1.
//     - On transfer with no accept, clear out_valid; out/OF_FLAG hold their
//       last value.
//     - Transfer and accept in the same cycle: load the new result and keep
//       out_valid=1. No bubble.
//     - Stall (out_valid && !out_ready): out/OF_FLAG stable, in_ready=0;
//       inputs are ignored even when in_valid=1.
//   Condition codes:
//     - Updated on accept with set_cc=1, in the same edge as out:
//       ZF=(result==0), SF=result[WIDTH-1], OF=overflow flag.
//     - Unchanged on accept with set_cc=0 and on non-accept cycles.
//     - cc reflects the most recently accepted set_cc op, even if its result
//       has not yet transferred.
//   Reset mid-operation: a pending result is dropped (out_valid=0) and cc
//     returns to CC_RESET.
//   No X propagation: inputs sampled only on accept.
// TESTING
//   1. add 45+38, set_cc=1, out_ready=1
//      -> next cycle out=83, OF_FLAG=0, out_valid=1; cc=000.
//   2. sub 45-45, set_cc=1 -> out=0, cc=100; then xor 45^38 (6'b101101^
//      6'b100110), set_cc=0 -> out=11, cc still 100.
//   3. add 0x7FFF_FFFF_FFFF_FFFF+1 -> out=0x8000_0000_0000_0000, OF_FLAG=1,
//      cc=011. Then sub max-(-1) -> out=0x8000..0, OF_FLAG=1.
//   4. and -45 & 38: out=(-45)&38=2, OF_FLAG=0. Also -45-(-38) -> out=-7,
//      cc=010.
//   5. Back-to-back 4 ops with out_ready low for 3 cycles after the first:
//      first result held, in_ready=0, no op lost or duplicated, order kept.
//   6. Assert rst while out_valid=1 and cc=011 -> out_valid=0, out=0, cc=100
//      immediately without a clock edge.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Operand/result bus for the execute stage.
//   master : decode side + downstream sink (drives operands and out_ready)
//   slave  : the execute stage itself
// Signals: in_valid/in_ready/OPCODE/in1/in2/set_cc (operation in),
//          out_valid/out_ready/out/OF_FLAG (result out), cc ({ZF,SF,OF}).
interface alu_exec_stage_if #(
   parameter int WIDTH = 64
);
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              OPCODE;
   logic signed [WIDTH-1:0] in1;
   logic signed [WIDTH-1:0] in2;
   logic                    set_cc;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out;
   logic                    OF_FLAG;
   logic [2:0]              cc;

   modport master (
      output in_valid, OPCODE, in1, in2, set_cc, out_ready,
      input  in_ready, out_valid, out, OF_FLAG, cc
   );

   modport slave (
      input  in_valid, OPCODE, in1, in2, set_cc, out_ready,
      output in_ready, out_valid, out, OF_FLAG, cc
   );
endinterface

// File: rtl/alu_exec_stage.sv
// Registered execute stage around a signed two's-complement ALU.
// Accepts one operation per cycle over valid/ready, registers the result and
// its signed-overflow flag, and maintains the {ZF,SF,OF} condition codes.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - alu_exec_stage_if.slave (operands in, result out, cc)
module alu_exec_stage #(
   parameter int         WIDTH    = 64,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic              clk,
   input  logic              rst,
   alu_exec_stage_if.slave   bus
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;

   function automatic logic signed [WIDTH-1:0] alu_calc(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b
   );
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         default: return a ^ b;
      endcase
   endfunction

   // Overflow is read from the operand and result sign bits only.
   function automatic logic alu_ovf(
      input logic [1:0]              op,
      input logic signed [WIDTH-1:0] a,
      input logic signed [WIDTH-1:0] b,
      input logic signed [WIDTH-1:0] r
   );
      case (op)
         OP_ADD:  return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         OP_SUB:  return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
         default: return 1'b0;
      endcase
   endfunction

   logic signed [WIDTH-1:0] res_p0;
   logic                    ovf_p0;
   logic                    acc_p0;

   logic signed [WIDTH-1:0] out_p1;
   logic                    ovf_p1;
   logic                    vld_p1;
   logic [2:0]              cc_p1;

   // Stage 0: combinational ALU on the presented operands
   always_comb begin
      res_p0 = alu_calc(bus.OPCODE, bus.in1, bus.in2);
      ovf_p0 = alu_ovf(bus.OPCODE, bus.in1, bus.in2, res_p0);
   end

   // Ready depends only on the output register and out_ready, never on in_valid.
   assign bus.in_ready = !vld_p1 || bus.out_ready;
   assign acc_p0       = bus.in_valid && bus.in_ready;

   // Stage 1: result register and condition codes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         out_p1 <= '0;
         ovf_p1 <= 1'b0;
         cc_p1  <= CC_RESET;
      end else begin
         if (acc_p0) begin
            vld_p1 <= 1'b1;
            out_p1 <= res_p0;
            ovf_p1 <= ovf_p0;
            if (bus.set_cc)
               cc_p1 <= {(res_p0 == '0), res_p0[WIDTH-1], ovf_p0};
         end else if (bus.out_ready) begin
            // Result consumed with nothing new behind it; data holds.
            vld_p1 <= 1'b0;
         end
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out       = out_p1;
   assign bus.OF_FLAG   = ovf_p1;
   assign bus.cc        = cc_p1;

endmodule
